// File: rtl/mul_arb_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing arbiter.
package mul_arb_pkg;

  localparam int OPW = 16;
  localparam int PW  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Bits needed to count 0..n-1; never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod N.
module rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = cnt_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt_idx      = IW'(idx);
        gnt[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one serial 16x16 multiplier between N requesters,
// with a watchdog that aborts an op whose done never arrives.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*16-1:0]  req_a,
  input  logic [N*16-1:0]  req_b,
  output logic [N-1:0]     ack,
  output logic [31:0]      res,
  output logic             busy,
  output logic             err,
  output logic             mul_start,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  input  logic [31:0]      mul_p,
  input  logic             mul_done
);

  localparam int IW = cnt_w(N);
  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [CW-1:0] cnt;

  logic [N-1:0][OPW-1:0] op_a;
  logic [N-1:0][OPW-1:0] op_b;

  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign op_a[g] = req_a[OPW*g +: OPW];
    assign op_b[g] = req_b[OPW*g +: OPW];
  end

  rr_arbiter #(.N(N)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      ack       <= '0;
      res       <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_start <= 1'b0;
      ack       <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            win       <= gnt_idx;
            mul_a     <= op_a[gnt_idx];
            mul_b     <= op_b[gnt_idx];
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        // mul_done may still be high from the previous op here, so it is not looked at.
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mul_done) begin
            res      <= mul_p;
            ack[win] <= 1'b1;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            err      <= 1'b1;
            res      <= '0;
            ack[win] <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          ptr   <= (win == IW'(N - 1)) ? '0 : win + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The grant vector is only consumed through its index.
  logic unused_gnt;
  assign unused_gnt = ^gnt;

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one multiplier_16bit_serial instance between N image-pipeline requesters (e.g. per-channel scaling/convolution stages).
- Round-robin arbitration; one multiply in flight at a time.
- Sequences the multiplier's start/done handshake and returns the 32-bit product to the granted requester with a one-cycle ack.
- A timeout watchdog guards against a multiplier that never signals done.

Parameters:
N, 4, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before abort (must exceed multiplier latency, nominally ~18 cycles)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
req  in  N  level request per requester; operands must be held until that requester's ack
req_a  in  N*16  operand A per requester, slice i = [16*i+15:16*i]
req_b  in  N*16  operand B per requester, same slicing
ack  out  N  one-hot, one-cycle pulse; res valid in the same cycle
res  out  32  product for the acked requester
busy  out  1  high in every state except IDLE
err  out  1  sticky timeout flag; cleared only by reset
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  16  operand A to the multiplier, held stable from ISSUE through WAIT
mul_b  out  16  operand B to the multiplier, held stable from ISSUE through WAIT
mul_p  in  32  multiplier product
mul_done  in  1  multiplier completion; product valid while high

Behaviour:
- Reset (rst=0, async): state=IDLE, ack=0, res=0, busy=0, err=0, mul_start=0, mul_a=0, mul_b=0, rr pointer=0, timeout counter=0. The multiplier shares rst, so an in-flight op is dropped silently with no ack.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set, pick the winner combinationally.
  - Winner is the first set bit at or after ptr, wrapping modulo N.
  - Register the winner index, mul_a=req_a[win], mul_b=req_b[win].
  - Transition to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle. Clear the counter and go to WAIT. mul_done is ignored here because it may be stale from the previous op.
- WAIT: increment the counter each cycle.
  - If mul_done=1: capture mul_p into res and go to RESP.
  - Else, if counter==TIMEOUT-1: set err, res=0, go to RESP.
  - mul_done takes priority over the timeout when both occur in the same cycle.
- RESP:
  - ack[win]=1 for one cycle; res holds the value captured in WAIT.
  - ptr = (win+1) mod N.
  - Go to IDLE.
- res holds its value until the next RESP. ack is 0 outside RESP.
- Latency: req seen in IDLE at cycle t → mul_start at t+1. If mul_done is first high at cycle d ≥ t+2, ack is at d+1.
- Throughput: at least one IDLE cycle between ops. The next grant can be decided in the IDLE cycle right after RESP.
- Held requests: a requester whose req stays high after its ack is re-arbitrated. Round-robin then serves the other pending requesters first.
- Dropped request: if req[win] deasserts after the grant, the op still completes and the ack still pulses. Requesters must not rely on aborting.
- Arithmetic: unsigned 16×16→32; the arbiter performs no arithmetic on the data.
- Single requester, continuous req: served every op with no starvation. With N all requesting, each is served once per N ops.

Decomposition:
- Package mul_arb_pkg: OPW=16, PW=32, state enum {IDLE, ISSUE, WAIT, RESP}, and a TIMEOUT counter width function (clog2).
- Sub-module rr_arbiter (parameter N): inputs req and ptr; outputs a one-hot grant, the grant index, and a valid flag. Purely combinational; the pointer register stays in mul_share_arbiter.
- mul_share_arbiter holds the FSM, operand/result registers and watchdog. It does not instantiate the multiplier; the top level wires it to multiplier_16bit_serial.

Test Plan:
- Single request: req=4'b0001, A=3, B=7 → mul_start one cycle after req; ack=4'b0001 one cycle after mul_done; res=21; err=0.
- Round-robin: req=4'b1111 held, A_i=i+1, B_i=100 → ack order 0,1,2,3,0; res=100,200,300,400,100; exactly one mul_start per ack.
- Timeout: multiplier stub never asserts done, req=4'b0100 → ack=4'b0100 exactly TIMEOUT+1 cycles after mul_start; res=0; err=1 and stays 1 through later successful ops.
- Max operands plus stale done: A=B=16'hFFFF, stub holds mul_done high during ISSUE → the stale done is ignored; final res=32'hFFFE0001.
- Reset mid-operation: assert rst=0 during WAIT → all outputs 0 immediately (async), no ack. After release, req=4'b0010 with A=5, B=9 → res=45, served first because ptr=0 and only requester 1 is pending.
- Randomized soak with the real multiplier_16bit_serial: 10000 ops, random req/operands → every ack's res equals A*B of the acked requester; no starvation (each pending requester acked within N ops).
